alu_port_arbiter: RTL and testbench
===================================

# alu_port_arbiter

Round-robin arbiter that shares the ALU's 4:1 operand mux among four requesters. It turns per-requester request lines into a registered one-hot grant and the matching 2-bit mux select, holding ownership until the owner releases its request. An optional hold timeout forces rotation so no requester can monopolise the ALU.

## Interface

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner when the timeout is compiled in. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  4  request per requester; the requester holds it high until finished.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- sel  output  2  registered mux select; equals the index of the set bit in gnt.
- sel_valid  output  1  high when gnt is non-zero.
- timeout  output  1  one-cycle pulse on the edge a forced rotation occurs. Tied to 0 when ARB_TIMEOUT_EN is undefined.

## Operation

- Two states, IDLE and GRANT. The state register, a 2-bit round-robin pointer `last` and an 8-bit hold counter `cnt` are internal.
- Round-robin search:
  - Order is last+1, last+2, last+3, last (mod 4).
  - The first index with req high wins.
  - On every new grant, `last` is set to the winner.
- IDLE:
  - If any req bit is high, grant the search winner on the next edge and move to GRANT with cnt=0.
  - Otherwise stay in IDLE.
- GRANT, owner o:
  - **Release:** if req[o] is low, re-arbitrate on the same edge over the other requesters, searching from o+1.
    - If a winner is found, grant it directly with no idle bubble, and set cnt=0.
    - If no other requester is pending, go to IDLE: gnt=0, sel_valid=0, and sel holds its last value.
  - **Hold:** if req[o] stays high, keep the grant and set cnt=cnt+1, saturating at MAX_HOLD-1.
- A requester that raises and drops req while another requester owns the grant is not remembered.
- gnt is never multi-hot. sel always matches the gnt index when sel_valid is high.

## Timing

- Reset (rst_n low, asynchronous): gnt=0, sel=0, sel_valid=0, timeout=0, state=IDLE, last=3, cnt=0. The first grant after reset favours requester 0.
- Latency is one cycle: req sampled at edge N gives gnt, sel and sel_valid valid after edge N.
- Release latency: the owner dropping req before edge N means the next owner's grant is visible after edge N.
- Simultaneous requests in IDLE: the winner is decided purely by the pointer, never by index priority.
- Owner drop coinciding with a timeout: the drop takes precedence, and timeout stays 0.
- Asserting rst_n low mid-grant clears outputs immediately, without waiting for a clock edge. Arbitration resumes from last=3.

## Configuration

- Macro: ARB_TIMEOUT_EN.
- **Defined:** in GRANT, when cnt==MAX_HOLD-1, req[o] is still high and another req bit is high, the next edge:
  - grants the round-robin winner among the others,
  - sets cnt=0,
  - pulses timeout for one cycle.
  - If no other request is pending, the owner keeps the grant and cnt stays saturated. Rotation happens on the first edge at which another request is seen.
- **Undefined:** no preemption; the owner keeps the grant until it drops req. cnt is not implemented and timeout is tied to 0.

## Test plan

- Reset, then req=4'b0000 for 3 cycles -> gnt=0, sel_valid=0, sel=0; asserting rst_n low mid-cycle clears outputs without a clock edge.
- req=4'b1111 at edge 1, each owner dropping its req after 2 cycles of grant -> grant order 0,1,2,3 with gnt 0001,0010,0100,1000 and sel 0,1,2,3, with no idle cycle between owners.
- req=4'b0100 only, then drop -> gnt=0100 and sel=2 one cycle later; after the drop gnt=0, sel_valid=0, and sel stays 2.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4, req[1] held high and req[3] raised at cycle 1 -> gnt=0010 for 4 cycles, then gnt=1000, sel=3, with timeout high for exactly that one cycle.
- ARB_TIMEOUT_EN defined, only req[0] held for 20 cycles -> gnt=0001 throughout and timeout never pulses; raising req[2] then gives gnt=0100 one cycle later, with a timeout pulse.
- ARB_TIMEOUT_EN undefined, same stimulus as the MAX_HOLD=4 case -> gnt=0010 until req[1] drops, timeout stays 0.

Source files
------------

// File: rtl/alu_port_arbiter_if.sv
// Request/grant bundle between the ALU operand mux requesters and
// the round-robin port arbiter.
interface alu_port_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  sel_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output sel_valid,
        output timeout
    );
endinterface

// File: rtl/alu_port_arbiter.sv
// Round-robin owner arbiter for the ALU 4:1 operand mux.
// ARB_TIMEOUT_EN compiles in the MAX_HOLD forced-rotation timeout.
module alu_port_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] last;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       vld_q;
    logic       to_q;

    logic [3:0] mask;
    logic [1:0] base;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    logic       own_req;

    assign own_req = bus.req[sel_q];

    // In GRANT the owner is excluded and the search starts after it.
    always_comb begin
        mask  = bus.req;
        base  = last;
        found = 1'b0;
        win   = last;
        idx   = '0;
        if (state == GRANT) begin
            mask[sel_q] = 1'b0;
            base        = sel_q;
        end
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
    logic [7:0] cnt;
`else
    localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
    logic unused_cfg;
    assign unused_cfg = ^HOLD_TOP;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 2'd3;
            gnt_q <= '0;
            sel_q <= '0;
            vld_q <= 1'b0;
            to_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            to_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gnt_q <= 4'b0001 << win;
                        sel_q <= win;
                        vld_q <= 1'b1;
                        last  <= win;
`ifdef ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!own_req) begin
                        if (found) begin
                            gnt_q <= 4'b0001 << win;
                            sel_q <= win;
                            last  <= win;
`ifdef ARB_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            gnt_q <= '0;
                            vld_q <= 1'b0;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt == HOLD_TOP && found) begin
                        gnt_q <= 4'b0001 << win;
                        sel_q <= win;
                        last  <= win;
                        cnt   <= '0;
                        to_q  <= 1'b1;
                    end else if (cnt != HOLD_TOP) begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = vld_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_alu_port_arbiter.sv
// Directed vector bench for alu_port_arbiter (MAX_HOLD=4).
module tb_alu_port_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_port_arbiter_if bus();

    alu_port_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] s, input logic v);
        vq.push_back('{r, g, s, v});
    endtask

    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] g,
                       input logic [1:0] s, input logic v,
                       input logic t);
        total++;
        if (bus.gnt !== g || bus.sel !== s ||
            bus.sel_valid !== v || bus.timeout !== t) begin
            bad++;
            $display("FAIL %s: got gnt=%b sel=%0d vld=%b to=%b, want gnt=%b sel=%0d vld=%b to=%b",
                     nm, bus.gnt, bus.sel, bus.sel_valid, bus.timeout,
                     g, s, v, t);
        end
    endtask

    initial begin
        bus.req = '0;
        // idle, then 1111 with each owner holding two cycles
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        add(4'b1110, 4'b0010, 2'd1, 1'b1);
        add(4'b1110, 4'b0010, 2'd1, 1'b1);
        add(4'b1100, 4'b0100, 2'd2, 1'b1);
        add(4'b1100, 4'b0100, 2'd2, 1'b1);
        add(4'b1000, 4'b1000, 2'd3, 1'b1);
        add(4'b1000, 4'b1000, 2'd3, 1'b1);
        add(4'b0000, 4'b0000, 2'd3, 1'b0);
        // single requester 2, sel held after drop
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        // pointer-driven choice, direct handover on release
        add(4'b0011, 4'b0001, 2'd0, 1'b1);
        add(4'b0010, 4'b0010, 2'd1, 1'b1);
        add(4'b0000, 4'b0000, 2'd1, 1'b0);
        add(4'b1001, 4'b1000, 2'd3, 1'b1);
        add(4'b0001, 4'b0001, 2'd0, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0);
        // transient request while owned is forgotten
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0110, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);

        #12;
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].req);
            chk($sformatf("vec%0d", i), vq[i].gnt, vq[i].sel,
                vq[i].vld, 1'b0);
        end

        // hold timeout: last=2, req1 then req3 joins
        step(4'b0010);
        chk("to_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1010);
            chk($sformatf("to_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(4'b1010);
        chk("to_rot", TO ? 4'b1000 : 4'b0010, TO ? 2'd3 : 2'd1,
            1'b1, TO);
        step(4'b1010);
        chk("to_after", TO ? 4'b1000 : 4'b0010, TO ? 2'd3 : 2'd1,
            1'b1, 1'b0);
        step(4'b1000);
        chk("to_drop1", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000);
        chk("to_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // lone owner never times out; rotates once another appears
        step(4'b0001);
        chk("solo_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'b0001);
            chk($sformatf("solo%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0101);
        chk("solo_rot", TO ? 4'b0100 : 4'b0001, TO ? 2'd2 : 2'd0,
            1'b1, TO);
        step(4'b0000);
        chk("solo_idle", 4'b0000, TO ? 2'd2 : 2'd0, 1'b0, 1'b0);

        // owner drops on the cycle its hold saturates
        step(4'b0001);
        chk("dt_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0101);
            chk($sformatf("dt_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0100);
        chk("dt_drop", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0000);
        chk("dt_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // async reset mid-grant, then pointer back at 3
        step(4'b0001);
        chk("ar_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001);
        chk("ar_resume", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0000);
        chk("ar_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
